// File: rtl/cache_arbiter.sv
// cache_arbiter: serialises I-cache fills, D-cache fills and D-cache write-backs onto one L2 port.
// Define CACHE_ARB_RR_EN for round-robin on contention; default build is fixed D-over-I priority.
module cache_arbiter #(
   parameter int ADDR_W = 16,
   parameter int LINE_W = 128
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_address,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              l2_read,
   output logic              l2_write,
   output logic [ADDR_W-1:0] l2_address,
   output logic [LINE_W-1:0] l2_wdata,
   input  logic [LINE_W-1:0] l2_rdata,
   input  logic              l2_resp
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic              i_req;
   logic              d_req;
   logic              prio_d;
   logic              grant_d;
   logic              grant_i;
   logic              nx_read;
   logic              nx_write;
   logic [ADDR_W-1:0] nx_address;
   logic [LINE_W-1:0] nx_wdata;

   assign i_req   = i_read;
   assign d_req   = d_read | d_write;
   assign i_rdata = l2_rdata;
   assign d_rdata = l2_rdata;

`ifdef CACHE_ARB_RR_EN
   localparam logic LG_I = 1'b0;
   localparam logic LG_D = 1'b1;

   logic last_grant;

   // Remember who finished last so contention favours the other side.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_grant <= LG_I;
      end else if (i_resp) begin
         last_grant <= LG_I;
      end else if (d_resp) begin
         last_grant <= LG_D;
      end
   end

   assign prio_d = (last_grant == LG_I);
`else
   assign prio_d = 1'b1;
`endif

   // Next-state, next L2 request registers and per-L1 resp strobes.
   always_comb begin
      state_nx   = state;
      nx_read    = l2_read;
      nx_write   = l2_write;
      nx_address = l2_address;
      nx_wdata   = l2_wdata;
      grant_d    = 1'b0;
      grant_i    = 1'b0;
      i_resp     = 1'b0;
      d_resp     = 1'b0;
      unique case (state)
         IDLE: begin
            grant_d = d_req & (~i_req | prio_d);
            grant_i = i_req & ~grant_d;
            if (grant_d) begin
               state_nx   = SERVE_D;
               nx_read    = ~d_write;
               nx_write   = d_write;
               nx_address = d_address;
               nx_wdata   = d_write ? d_wdata : '0;
            end else if (grant_i) begin
               state_nx   = SERVE_I;
               nx_read    = 1'b1;
               nx_write   = 1'b0;
               nx_address = i_address;
               nx_wdata   = '0;
            end
         end
         SERVE_I: begin
            if (l2_resp) begin
               i_resp   = 1'b1;
               state_nx = IDLE;
               nx_read  = 1'b0;
               nx_write = 1'b0;
            end
         end
         SERVE_D: begin
            if (l2_resp) begin
               d_resp   = 1'b1;
               state_nx = IDLE;
               nx_read  = 1'b0;
               nx_write = 1'b0;
            end
         end
         default: begin
            state_nx = IDLE;
            nx_read  = 1'b0;
            nx_write = 1'b0;
         end
      endcase
   end

   // State and registered L2 request; reset abandons any transaction.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         l2_read    <= 1'b0;
         l2_write   <= 1'b0;
         l2_address <= '0;
         l2_wdata   <= '0;
      end else begin
         state      <= state_nx;
         l2_read    <= nx_read;
         l2_write   <= nx_write;
         l2_address <= nx_address;
         l2_wdata   <= nx_wdata;
      end
   end

   a_d_rw_excl : assert property (
      @(posedge clk) disable iff (!rst_n) !(d_read && d_write));
   a_resp_excl : assert property (
      @(posedge clk) disable iff (!rst_n) !(i_resp && d_resp));
   a_l2_excl : assert property (
      @(posedge clk) disable iff (!rst_n) !(l2_read && l2_write));

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed checks of the cache_arbiter L2 serialiser.
// Expectations follow CACHE_ARB_RR_EN when it is defined.
module tb_cache_arbiter;

   localparam int AW = 16;
   localparam int LW = 128;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_read;
   logic [AW-1:0] i_address;
   logic [LW-1:0] i_rdata;
   logic          i_resp;
   logic          d_read;
   logic          d_write;
   logic [AW-1:0] d_address;
   logic [LW-1:0] d_wdata;
   logic [LW-1:0] d_rdata;
   logic          d_resp;
   logic          l2_read;
   logic          l2_write;
   logic [AW-1:0] l2_address;
   logic [LW-1:0] l2_wdata;
   logic [LW-1:0] l2_rdata;
   logic          l2_resp;

   int n_cmp = 0;
   int n_err = 0;

   cache_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_read(i_read), .i_address(i_address),
      .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write),
      .d_address(d_address), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .l2_read(l2_read), .l2_write(l2_write),
      .l2_address(l2_address), .l2_wdata(l2_wdata),
      .l2_rdata(l2_rdata), .l2_resp(l2_resp)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; i_read = 0; d_read = 0; d_write = 0;
      i_address = '0; d_address = '0; d_wdata = '0;
      l2_rdata = '0; l2_resp = 0;
      tick(); tick();
      n_cmp++; if (l2_read !== 1'b0) begin n_err++;
         $display("FAIL rst_l2_read got %b want 0", l2_read); end
      n_cmp++; if (l2_write !== 1'b0) begin n_err++;
         $display("FAIL rst_l2_write got %b want 0", l2_write); end
      n_cmp++; if (l2_address !== 16'h0) begin n_err++;
         $display("FAIL rst_l2_address got %h want 0", l2_address); end
      n_cmp++; if (l2_wdata !== '0) begin n_err++;
         $display("FAIL rst_l2_wdata got %h want 0", l2_wdata); end
      n_cmp++; if ({i_resp, d_resp} !== 2'b00) begin n_err++;
         $display("FAIL rst_resp got %b want 00", {i_resp, d_resp}); end
      rst_n = 1'b1;
      tick();
   endtask

   // One I-cache fill; returns to IDLE with requests dropped.
   task automatic xact_i(input logic [AW-1:0] a,
                         input logic [LW-1:0] dat,
                         input int lat, input string tag);
      i_read = 1; i_address = a;
      tick();
      n_cmp++; if ({l2_read, l2_write} !== 2'b10) begin n_err++;
         $display("FAIL %s_op got %b want 10", tag, {l2_read, l2_write}); end
      n_cmp++; if (l2_address !== a) begin n_err++;
         $display("FAIL %s_addr got %h want %h", tag, l2_address, a); end
      for (int k = 1; k < lat; k++) tick();
      n_cmp++; if ({l2_read, i_resp} !== 2'b10) begin n_err++;
         $display("FAIL %s_wait got %b want 10", tag, {l2_read, i_resp}); end
      l2_resp = 1; l2_rdata = dat;
      #1;
      n_cmp++; if ({i_resp, d_resp} !== 2'b10) begin n_err++;
         $display("FAIL %s_resp got %b want 10", tag, {i_resp, d_resp}); end
      n_cmp++; if (i_rdata !== dat) begin n_err++;
         $display("FAIL %s_rdata got %h want %h", tag, i_rdata, dat); end
      tick();
      l2_resp = 0; i_read = 0;
      #1;
      n_cmp++; if ({l2_read, i_resp} !== 2'b00) begin n_err++;
         $display("FAIL %s_done got %b want 00", tag, {l2_read, i_resp}); end
      tick();
   endtask

   task automatic test_i_only();
      xact_i(16'h1230, {16{8'hA5}}, 5, "i_only");
   endtask

   task automatic test_d_write();
      logic [LW-1:0] wd;
      wd = {2{64'h0123456789ABCDEF}};
      d_write = 1; d_address = 16'h4000; d_wdata = wd;
      tick();
      n_cmp++; if ({l2_read, l2_write} !== 2'b01) begin n_err++;
         $display("FAIL dw_op got %b want 01", {l2_read, l2_write}); end
      n_cmp++; if (l2_wdata !== wd) begin n_err++;
         $display("FAIL dw_wdata got %h want %h", l2_wdata, wd); end
      n_cmp++; if (l2_address !== 16'h4000) begin n_err++;
         $display("FAIL dw_addr got %h want 4000", l2_address); end
      tick(); tick();
      l2_resp = 1;
      #1;
      n_cmp++; if ({i_resp, d_resp} !== 2'b01) begin n_err++;
         $display("FAIL dw_resp got %b want 01", {i_resp, d_resp}); end
      tick();
      l2_resp = 0; d_write = 0;
      #1;
      n_cmp++; if ({l2_write, d_resp} !== 2'b00) begin n_err++;
         $display("FAIL dw_done got %b want 00", {l2_write, d_resp}); end
      tick();
   endtask

   // Both request at once; d_first selects who is expected first.
   task automatic run_sim(input logic d_first, input string tag);
      i_read = 1; i_address = 16'h1111;
      d_read = 1; d_address = 16'h2222;
      for (int n = 0; n < 2; n++) begin
         logic srv_d;
         srv_d = (n == 0) ? d_first : ~d_first;
         tick();
         n_cmp++;
         if (l2_address !== (srv_d ? 16'h2222 : 16'h1111) || l2_read !== 1'b1) begin
            n_err++;
            $display("FAIL %s_grant%0d got addr %h rd %b want addr %h rd 1",
                     tag, n, l2_address, l2_read, srv_d ? 16'h2222 : 16'h1111);
         end
         l2_resp = 1;
         #1;
         n_cmp++; if ({i_resp, d_resp} !== {~srv_d, srv_d}) begin n_err++;
            $display("FAIL %s_resp%0d got %b want %b", tag, n,
                     {i_resp, d_resp}, {~srv_d, srv_d}); end
         tick();
         l2_resp = 0;
         if (srv_d) d_read = 0; else i_read = 0;
         #1;
         n_cmp++; if (l2_read !== 1'b0) begin n_err++;
            $display("FAIL %s_gap%0d got %b want 0", tag, n, l2_read); end
      end
      tick();
   endtask

   task automatic test_simultaneous();
`ifdef CACHE_ARB_RR_EN
      run_sim(1'b0, "sim_lgd");
`else
      run_sim(1'b1, "sim_a");
`endif
      xact_i(16'h0AB0, {16{8'h3C}}, 1, "i_mid");
      run_sim(1'b1, "sim_lgi");
   endtask

   task automatic test_reset_mid();
      i_read = 1; i_address = 16'h5550;
      tick();
      n_cmp++; if (l2_read !== 1'b1) begin n_err++;
         $display("FAIL rm_start got %b want 1", l2_read); end
      tick();
      rst_n = 0;
      tick();
      n_cmp++;
      if ({l2_read, l2_write, i_resp, d_resp} !== 4'b0 || l2_address !== 16'h0) begin
         n_err++;
         $display("FAIL rm_clear got %b addr %h want 0000 addr 0",
                  {l2_read, l2_write, i_resp, d_resp}, l2_address);
      end
      rst_n = 1; i_read = 0;
      tick();
      l2_resp = 1;
      #1;
      n_cmp++; if ({i_resp, d_resp} !== 2'b00) begin n_err++;
         $display("FAIL rm_idle got %b want 00", {i_resp, d_resp}); end
      l2_resp = 0;
      d_read = 1; d_address = 16'h6660;
      tick();
      n_cmp++; if ({l2_read, l2_write} !== 2'b10 || l2_address !== 16'h6660) begin
         n_err++;
         $display("FAIL rm_d got %b addr %h want 10 addr 6660",
                  {l2_read, l2_write}, l2_address);
      end
      l2_resp = 1;
      #1;
      n_cmp++; if (d_resp !== 1'b1) begin n_err++;
         $display("FAIL rm_dresp got %b want 1", d_resp); end
      tick();
      l2_resp = 0; d_read = 0;
      tick();
   endtask

   task automatic test_robust();
      l2_resp = 1;
      #1;
      n_cmp++; if ({i_resp, d_resp} !== 2'b00) begin n_err++;
         $display("FAIL rb_idle got %b want 00", {i_resp, d_resp}); end
      tick();
      n_cmp++; if ({l2_read, l2_write, i_resp, d_resp} !== 4'b0) begin n_err++;
         $display("FAIL rb_idle2 got %b want 0000",
                  {l2_read, l2_write, i_resp, d_resp}); end
      l2_resp = 0;
      i_read = 1; i_address = 16'h7770;
      tick();
      i_address = 16'h7FF0;
      tick(); tick();
      n_cmp++; if (l2_address !== 16'h7770) begin n_err++;
         $display("FAIL rb_hold got %h want 7770", l2_address); end
      l2_resp = 1;
      #1;
      n_cmp++; if (i_resp !== 1'b1) begin n_err++;
         $display("FAIL rb_resp got %b want 1", i_resp); end
      tick();
      l2_resp = 0; i_read = 0;
      tick();
   endtask

   initial begin
      test_reset();
      test_i_only();
      test_d_write();
      test_simultaneous();
      test_reset_mid();
      test_robust();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Sits between the split L1 caches (I-cache, D-cache) and the unified L2 cache.
- Serialises L1 line-miss traffic onto the single L2 port: I-cache line fills, D-cache line fills and D-cache dirty write-backs, one lc3b_burst line per transaction.
- Grant selection is registered through a small FSM.
- Each requester sees the standard level-held request / single-cycle resp handshake.

Parameters:
- ADDR_W, 16, byte-address width of all address ports (lc3b_word).
- LINE_W, 128, line width in bits (lc3b_burst).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- i_read  in  1  I-cache line-fill request
- i_address  in  ADDR_W  I-cache line address
- i_rdata  out  LINE_W  fill data to I-cache
- i_resp  out  1  I-cache transaction done
- d_read  in  1  D-cache line-fill request
- d_write  in  1  D-cache write-back request
- d_address  in  ADDR_W  D-cache line address
- d_wdata  in  LINE_W  write-back data
- d_rdata  out  LINE_W  fill data to D-cache
- d_resp  out  1  D-cache transaction done
- l2_read  out  1  read request to L2
- l2_write  out  1  write request to L2
- l2_address  out  ADDR_W  L2 line address
- l2_wdata  out  LINE_W  L2 write data
- l2_rdata  in  LINE_W  L2 read data
- l2_resp  in  1  L2 transaction done

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous and active-low.
- Reset values: state=IDLE, last_grant=I; l2_read=0, l2_write=0, l2_address=0, l2_wdata=0; i_resp=0, d_resp=0.
- Reset mid-transaction abandons it with no resp to either L1. The L2 is reset by the same rst_n.
- Requests are level-held: an L1 holds read/write, address and wdata stable until it sees its resp.
- FSM states: IDLE, SERVE_I, SERVE_D.
- IDLE:
  - Evaluate i_req=i_read and d_req=d_read|d_write.
  - Neither → stay in IDLE.
  - One → grant it.
  - Both → grant D (fixed priority; see Optional Feature).
  - On grant, register into the l2 output registers: address, op (read or write), and wdata (D write only; else 0).
  - The granted state is entered on the same edge.
- Latency: request first seen in IDLE at edge t → l2_read/l2_write high from cycle t+1.
- SERVE_x:
  - l2 outputs are held constant from their registers.
  - The input request is not re-sampled, so a change on the L1 side is ignored.
  - Waits an unbounded number of cycles for l2_resp.
- On l2_resp=1 in SERVE_x:
  - x_resp=1 combinationally in that same cycle, for exactly one cycle.
  - x_rdata=l2_rdata in that cycle.
  - Next edge: state→IDLE, l2_read/l2_write→0, last_grant←x.
- One idle cycle between transactions is mandatory. The L1 drops its request in the cycle after resp, so no stale re-grant occurs.
- i_rdata and d_rdata are driven from l2_rdata unconditionally; only the resp signals are gated.
- l2_resp while in IDLE is ignored.
- d_read and d_write both high is illegal: d_write wins and a simulation assertion fires.
- i_resp and d_resp are never high in the same cycle.
- l2_read and l2_write are never high together.

Optional Feature:
- Macro: CACHE_ARB_RR_EN.
- Defined: when both requests are present in IDLE, grant the requester that is not last_grant (round-robin). Single requests are unaffected. No starvation: worst case, a waiting requester is served after one opposing transaction.
- Undefined: fixed D-over-I priority, and last_grant is unused. A persistently requesting D-cache can starve the I-cache (documented behaviour).

Test Plan:
- I only: i_read=1, i_address=0x1230, L2 resp after 5 cycles with l2_rdata=0xA5..A5.
  - l2_read=1, l2_address=0x1230 from the cycle after the request.
  - i_resp pulses 1 cycle with i_rdata=0xA5..A5; l2_read=0 next cycle.
- D write-back: d_write=1, d_address=0x4000, d_wdata=0x0123..CDEF.
  - l2_write=1, l2_wdata=0x0123..CDEF, l2_read=0.
  - d_resp pulses on l2_resp; i_resp stays 0.
- Simultaneous: i_read and d_read asserted at the same edge in IDLE.
  - D is served first (l2_address=d_address).
  - After d_resp, one IDLE cycle, then I is served.
- Simultaneous with CACHE_ARB_RR_EN and last_grant=D: I is served first, then D. Repeat with last_grant=I: D is served first.
- Reset mid-op: assert rst_n=0 while in SERVE_I with L2 not yet responded.
  - Next cycle all l2 outputs are 0, no resp is issued, and the FSM is in IDLE.
  - A new d_read afterwards is served normally.
- Robustness: l2_resp pulsed while in IDLE → no resp to either L1. Also change i_address mid-SERVE_I → l2_address holds its original value.
